option_store_ctrl: RTL and testbench
====================================

Name: option_store_ctrl

Overview:
Sits between the line parser and the option BRAM, and owns that BRAM.
- Load phase: takes the parser's 16-bit write stream (line headers followed by option words) and writes options contiguously into a single-port BRAM. Builds a per-line table of base address and option count.
- Ready phase: arbitrates BRAM reads between two solver requesters (0 = row engine, 1 = column engine). Translates (line, option index) into a BRAM address.

Parameters:
MAX_ROWS, 11, max board rows
MAX_COLS, 11, max board cols
MAX_NUM_OPTIONS, 84, max options per line; count width CW = $clog2(MAX_NUM_OPTIONS+1)
DEPTH, 1024, BRAM words; AW = $clog2(DEPTH)
BRAM_LATENCY, 2, read latency of BRAM in cycles
LW = $clog2(MAX_ROWS+MAX_COLS) (derived localparam, 5 at defaults)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
wr_valid  in  1  parser word valid (parser write_ready)
wr_is_header  in  1  qualifies wr_data as line header (parser flag==START_LINE)
wr_data  in  16  header: line index in [LW-1:0]; else option bitmap
board_done  in  1  parser end-of-board pulse
bram_addr  out  AW  BRAM address
bram_we  out  1  BRAM write enable
bram_din  out  16  BRAM write data
bram_dout  in  16  BRAM read data
req  in  2  per-requester read request, level, held until granted
req_line  in  2xLW  per-requester line index
req_idx  in  2xCW  per-requester option index
grant  out  2  one-hot, 1-cycle grant
rvalid  out  1  read data valid
rid  out  1  requester owning rvalid
rdata  out  16  read data
oor  out  1  with rvalid: request was out of range
load_done  out  1  table valid, reads enabled
overflow  out  1  sticky: BRAM full or option word before header

Behaviour:
- Reset values: all outputs 0, state IDLE, wr_ptr=0, table entries count=0 and base=0, rr pointer=0. Reset mid-load or mid-read aborts everything; in-flight rvalid is suppressed.
- States:
  - IDLE: header word -> LOAD. Option word -> drop it, set overflow.
  - LOAD: header -> cur_line=wr_data[LW-1:0], base[cur_line]=wr_ptr, count[cur_line]=0. Option -> bram_we=1, bram_addr=wr_ptr, bram_din=wr_data, wr_ptr+=1, count[cur_line]+=1, all in the same cycle. board_done -> READY, load_done=1 next cycle.
  - READY: header word -> LOAD with wr_ptr=0 and load_done=0 (the header is processed as in LOAD). Reads already granted still return rvalid.
- Write boundaries:
  - wr_ptr==DEPTH-1 is written normally.
  - Any further option is dropped, sets overflow, and leaves count unchanged.
  - count saturates at MAX_NUM_OPTIONS; an option beyond that is dropped and sets overflow.
  - board_done in the same cycle as wr_valid: the word is processed first, then the state moves to READY.
- Arbitration, READY only; no grants in IDLE or LOAD:
  - Round-robin. The rr pointer names the preferred requester and moves to the other requester after each grant.
  - One grant per cycle. Back-to-back grants are allowed.
  - grant[i] asserts in the cycle bram_addr = base[req_line[i]] + req_idx[i]. Arithmetic is AW-bit, with no wrap check beyond oor.
- Read pipeline:
  - rvalid, rid and rdata appear exactly BRAM_LATENCY cycles after grant. rdata = bram_dout.
  - If req_idx >= count[req_line] or req_line >= MAX_ROWS+MAX_COLS: the grant is still issued, then rvalid with rdata=0 and oor=1. bram_addr is driven to 0.
  - Pipeline tags are a shift register of depth BRAM_LATENCY carrying (valid, rid, oor).
- The requester deasserts req, or presents its next request, in the cycle after grant.
- Table storage: flops, (MAX_ROWS+MAX_COLS) x (AW+CW).

Optional Feature:
OPTION_STORE_FIXED_PRIORITY_EN.
- Defined: requester 0 (rows) always wins when both request; the rr pointer is not implemented.
- Undefined: round-robin as above.

Test Plan:
- Load line 0 with 3 options (0x0007, 0x000B, 0x000D) and line 1 with 2 options (0x0003, 0x0006), then board_done -> BRAM writes at addr 0..4, base={0,3}, count={3,2}, load_done=1 one cycle after board_done.
- READY, req[0] with line=1 idx=1 -> grant[0] the next cycle with bram_addr=4; rvalid, rid=0, rdata=0x0006 two cycles later.
- Both req high for 4 cycles, rr=0 -> grants alternate 0,1,0,1; with OPTION_STORE_FIXED_PRIORITY_EN -> grants 0,0,0,0.
- req[1] line=0 idx=3 -> grant, then rvalid with oor=1, rdata=0, rid=1.
- DEPTH=4, 5 options on one line -> 4 writes; 5th dropped, overflow=1, count=4.
- Assert rst while granted read in flight -> rvalid is never asserted; all outputs 0 the cycle after rst; header after rst -> LOAD.

Source files
------------

// File: rtl/option_store_ctrl_if.sv
// Parser write stream and solver read port of option_store_ctrl.
// master = parser/solver side, slave = option_store_ctrl.
interface option_store_ctrl_if #(
  parameter int unsigned LW = 5,
  parameter int unsigned CW = 7
);
  logic               wr_valid;
  logic               wr_is_header;
  logic [15:0]        wr_data;
  logic               board_done;
  logic [1:0]         req;
  logic [1:0][LW-1:0] req_line;
  logic [1:0][CW-1:0] req_idx;
  logic [1:0]         grant;
  logic               rvalid;
  logic               rid;
  logic [15:0]        rdata;
  logic               oor;

  modport master (
    output wr_valid, wr_is_header, wr_data, board_done, req, req_line, req_idx,
    input  grant, rvalid, rid, rdata, oor
  );

  modport slave (
    input  wr_valid, wr_is_header, wr_data, board_done, req, req_line, req_idx,
    output grant, rvalid, rid, rdata, oor
  );
endinterface

// File: rtl/option_store_ctrl.sv
// Owns the option BRAM: packs parser option words per line during load, then serves two
// arbitrated solver read ports. Define OPTION_STORE_FIXED_PRIORITY_EN to make the row engine win.
module option_store_ctrl #(
  parameter int unsigned MAX_ROWS        = 11,
  parameter int unsigned MAX_COLS        = 11,
  parameter int unsigned MAX_NUM_OPTIONS = 84,
  parameter int unsigned DEPTH           = 1024,
  parameter int unsigned BRAM_LATENCY    = 2,
  localparam int unsigned NLINES = MAX_ROWS + MAX_COLS,
  localparam int unsigned LW     = $clog2(NLINES),
  localparam int unsigned CW     = $clog2(MAX_NUM_OPTIONS + 1),
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  option_store_ctrl_if.slave bus,
  output logic [AW-1:0]      bram_addr,
  output logic               bram_we,
  output logic [15:0]        bram_din,
  input  logic [15:0]        bram_dout,
  output logic               load_done,
  output logic               overflow
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StReady = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] cur_line_q, cur_line_d;
  logic          load_done_q, load_done_d;
  logic          overflow_q, overflow_d;
  logic [AW-1:0] base_q [NLINES];
  logic [AW-1:0] base_d [NLINES];
  logic [CW-1:0] cnt_q  [NLINES];
  logic [CW-1:0] cnt_d  [NLINES];

  logic [BRAM_LATENCY-1:0] tag_v_q, tag_v_d;
  logic [BRAM_LATENCY-1:0] tag_id_q, tag_id_d;
  logic [BRAM_LATENCY-1:0] tag_oor_q, tag_oor_d;

  // Write-side decode
  logic          hdr, opt;
  logic [LW-1:0] hdr_line;
  logic          hdr_ok, cur_ok;
  logic [LW-1:0] cur_sel;
  logic          ptr_full, cnt_full;
  logic          wr_en;

  assign hdr      = bus.wr_valid && bus.wr_is_header;
  assign opt      = bus.wr_valid && !bus.wr_is_header;
  assign hdr_line = bus.wr_data[LW-1:0];
  assign hdr_ok   = 32'(hdr_line) < NLINES;
  assign cur_ok   = 32'(cur_line_q) < NLINES;
  assign cur_sel  = cur_ok ? cur_line_q : '0;
  assign ptr_full = wr_ptr_q == (AW+1)'(DEPTH);
  assign cnt_full = cur_ok && (cnt_q[cur_sel] == CW'(MAX_NUM_OPTIONS));

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    cur_line_d  = cur_line_q;
    load_done_d = load_done_q;
    overflow_d  = overflow_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    wr_en       = 1'b0;
    if (hdr) begin
      // A header while READY starts a fresh board from address 0.
      if (state_q == StReady) begin
        wr_ptr_d    = '0;
        load_done_d = 1'b0;
      end
      cur_line_d = hdr_line;
      if (hdr_ok) begin
        base_d[hdr_line] = wr_ptr_d[AW-1:0];
        cnt_d[hdr_line]  = '0;
      end
      state_d = StLoad;
    end else if (opt) begin
      if (state_q == StIdle) begin
        overflow_d = 1'b1;
      end else if (state_q == StLoad) begin
        if (ptr_full || cnt_full) begin
          overflow_d = 1'b1;
        end else begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (cur_ok) begin
            cnt_d[cur_sel] = cnt_q[cur_sel] + 1'b1;
          end
        end
      end
      // Option words arriving while READY have no line context and are ignored.
    end
    if (bus.board_done && state_d == StLoad) begin
      state_d     = StReady;
      load_done_d = 1'b1;
    end
  end

  // Read-side arbitration and address translation
  logic          gnt_any, gnt_id;
  logic [LW-1:0] rd_line, rd_sel;
  logic [CW-1:0] rd_idx;
  logic          rd_line_ok, rd_oor;
  logic [AW-1:0] rd_addr;
  logic [1:0]    grant;

`ifndef OPTION_STORE_FIXED_PRIORITY_EN
  logic rr_q, rr_d;
`endif

  always_comb begin
    gnt_any = (state_q == StReady) && (|bus.req);
`ifdef OPTION_STORE_FIXED_PRIORITY_EN
    gnt_id  = !bus.req[0];
`else
    gnt_id  = (&bus.req) ? rr_q : bus.req[1];
    rr_d    = gnt_any ? !gnt_id : rr_q;
`endif
    rd_line    = bus.req_line[gnt_id];
    rd_idx     = bus.req_idx[gnt_id];
    rd_line_ok = 32'(rd_line) < NLINES;
    rd_sel     = rd_line_ok ? rd_line : '0;
    rd_oor     = !rd_line_ok || (rd_idx >= cnt_q[rd_sel]);
    rd_addr    = base_q[rd_sel] + AW'(rd_idx);
    grant      = gnt_any ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
  end

  // Writes and grants never coincide: writes only in LOAD, grants only in READY.
  always_comb begin
    bram_we  = wr_en;
    bram_din = wr_en ? bus.wr_data : '0;
    if (wr_en) begin
      bram_addr = wr_ptr_q[AW-1:0];
    end else if (gnt_any && !rd_oor) begin
      bram_addr = rd_addr;
    end else begin
      bram_addr = '0;
    end
  end

  always_comb begin
    tag_v_d      = tag_v_q;
    tag_id_d     = tag_id_q;
    tag_oor_d    = tag_oor_q;
    tag_v_d[0]   = gnt_any;
    tag_id_d[0]  = gnt_any && gnt_id;
    tag_oor_d[0] = gnt_any && rd_oor;
    for (int i = 1; i < BRAM_LATENCY; i++) begin
      tag_v_d[i]   = tag_v_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
      tag_oor_d[i] = tag_oor_q[i-1];
    end
  end

  logic rvalid;
  assign rvalid     = tag_v_q[BRAM_LATENCY-1];
  assign bus.grant  = grant;
  assign bus.rvalid = rvalid;
  assign bus.rid    = rvalid && tag_id_q[BRAM_LATENCY-1];
  assign bus.oor    = rvalid && tag_oor_q[BRAM_LATENCY-1];
  assign bus.rdata  = (rvalid && !tag_oor_q[BRAM_LATENCY-1]) ? bram_dout : '0;
  assign load_done  = load_done_q;
  assign overflow   = overflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      cur_line_q  <= '0;
      load_done_q <= 1'b0;
      overflow_q  <= 1'b0;
      tag_v_q     <= '0;
      tag_id_q    <= '0;
      tag_oor_q   <= '0;
      for (int i = 0; i < NLINES; i++) begin
        base_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      cur_line_q  <= cur_line_d;
      load_done_q <= load_done_d;
      overflow_q  <= overflow_d;
      tag_v_q     <= tag_v_d;
      tag_id_q    <= tag_id_d;
      tag_oor_q   <= tag_oor_d;
      base_q      <= base_d;
      cnt_q       <= cnt_d;
    end
  end

`ifndef OPTION_STORE_FIXED_PRIORITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

endmodule

// File: tb/tb_option_store_ctrl.sv
// Scoreboard bench for option_store_ctrl: default-size instance plus a DEPTH=4 instance
// for the BRAM-full boundary.
`timescale 1ns/1ps
module tb_option_store_ctrl;
  localparam int unsigned LW  = 5;
  localparam int unsigned CW  = 7;
  localparam int unsigned AW  = 10;
  localparam int unsigned AW2 = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  option_store_ctrl_if #(.LW(LW), .CW(CW)) bus ();
  option_store_ctrl_if #(.LW(LW), .CW(CW)) bus2 ();

  logic [AW-1:0]  bram_addr;
  logic           bram_we;
  logic [15:0]    bram_din, bram_dout;
  logic           load_done, overflow;
  logic [AW2-1:0] bram_addr2;
  logic           bram_we2;
  logic [15:0]    bram_din2, bram_dout2;
  logic           load_done2, overflow2;

  option_store_ctrl dut (
    .clk(clk), .rst(rst), .bus(bus),
    .bram_addr(bram_addr), .bram_we(bram_we), .bram_din(bram_din), .bram_dout(bram_dout),
    .load_done(load_done), .overflow(overflow)
  );

  option_store_ctrl #(.DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2),
    .bram_addr(bram_addr2), .bram_we(bram_we2), .bram_din(bram_din2), .bram_dout(bram_dout2),
    .load_done(load_done2), .overflow(overflow2)
  );

  // Behavioural BRAMs, 2-cycle read latency
  logic [15:0] mem [1024];
  logic [15:0] rd_p1, rd_p2;
  logic [15:0] mem2 [4];
  logic [15:0] rd2_p1, rd2_p2;
  always @(posedge clk) begin
    if (bram_we) mem[bram_addr] <= bram_din;
    rd_p1 <= mem[bram_addr];
    rd_p2 <= rd_p1;
    if (bram_we2) mem2[bram_addr2] <= bram_din2;
    rd2_p1 <= mem2[bram_addr2];
    rd2_p2 <= rd2_p1;
  end
  assign bram_dout  = rd_p2;
  assign bram_dout2 = rd2_p2;

  int unsigned cyc = 0;
  int unsigned we2_cnt;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) we2_cnt <= 0;
    else if (bram_we2) we2_cnt <= we2_cnt + 1;
  end

  typedef struct { logic id; logic [15:0] data; logic oor; int unsigned cyc; } rd_exp_t;
  typedef struct { logic [9:0] addr; logic [15:0] data; } wr_exp_t;
  rd_exp_t exp_q[$];
  wr_exp_t wq[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Read-response monitor
  always @(negedge clk) begin
    rd_exp_t e;
    if (bus.rvalid) begin
      if (exp_q.size() == 0) begin
        check("rvalid_unexpected", 32'(bus.rvalid), 0);
      end else begin
        e = exp_q.pop_front();
        check("rid", 32'(bus.rid), 32'(e.id));
        check("rdata", 32'(bus.rdata), 32'(e.data));
        check("oor", 32'(bus.oor), 32'(e.oor));
        check("rlatency", cyc, e.cyc);
      end
    end
  end

  // BRAM write monitor
  always @(negedge clk) begin
    wr_exp_t w;
    if (bram_we) begin
      if (wq.size() == 0) begin
        check("we_unexpected", 32'(bram_we), 0);
      end else begin
        w = wq.pop_front();
        check("waddr", 32'(bram_addr), 32'(w.addr));
        check("wdata", 32'(bram_din), 32'(w.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic hdr, input logic [15:0] d);
    bus.wr_valid     = 1'b1;
    bus.wr_is_header = hdr;
    bus.wr_data      = d;
    tick();
    bus.wr_valid     = 1'b0;
    bus.wr_is_header = 1'b0;
  endtask

  task automatic opt_exp(input logic [9:0] a, input logic [15:0] d);
    wq.push_back('{a, d});
    wr(1'b0, d);
  endtask

  task automatic done();
    bus.board_done = 1'b1;
    @(negedge clk);
    check("load_done_same_cycle", 32'(load_done), 0);
    @(posedge clk);
    #1;
    bus.board_done = 1'b0;
    @(negedge clk);
    check("load_done_next_cycle", 32'(load_done), 1);
    tick();
  endtask

  task automatic rd(input int r, input logic [4:0] line, input logic [6:0] idx,
                    input logic [15:0] data, input logic o, input logic [9:0] addr);
    bit got = 1'b0;
    bus.req[r]      = 1'b1;
    bus.req_line[r] = line;
    bus.req_idx[r]  = idx;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (bus.grant != 2'b00) begin
        got = 1'b1;
        check("grant_onehot", 32'(bus.grant), 32'(1) << r);
        check("rd_addr", 32'(bram_addr), 32'(addr));
        exp_q.push_back('{r[0], data, o, cyc + 2});
      end
      tick();
    end
    bus.req[r] = 1'b0;
    if (!got) check("grant_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.wr_valid = 0; bus.wr_is_header = 0; bus.wr_data = 0; bus.board_done = 0;
    bus.req = 0; bus.req_line = '0; bus.req_idx = '0;
    bus2.wr_valid = 0; bus2.wr_is_header = 0; bus2.wr_data = 0; bus2.board_done = 0;
    bus2.req = 0; bus2.req_line = '0; bus2.req_idx = '0;
    tick();
    tick();
    @(negedge clk);
    check("reset_outs", {30'(bus.grant), bus.rvalid, bram_we}, 0);
    check("reset_status", {load_done, overflow, bus.rdata, 6'(bram_addr)}, 0);
    tick();
    rst = 1'b0;

    // Load: line 0 = {7,B,D}, line 1 = {3,6}
    wr(1'b1, 16'd0);
    opt_exp(10'd0, 16'h0007);
    opt_exp(10'd1, 16'h000B);
    opt_exp(10'd2, 16'h000D);
    wr(1'b1, 16'd1);
    opt_exp(10'd3, 16'h0003);
    opt_exp(10'd4, 16'h0006);
    done();
    check("overflow_after_load", 32'(overflow), 0);

    rd(0, 5'd1, 7'd1, 16'h0006, 1'b0, 10'd4);
    rd(1, 5'd0, 7'd3, 16'h0000, 1'b1, 10'd0);
    rd(0, 5'd30, 7'd0, 16'h0000, 1'b1, 10'd0);  // line beyond table
    rd(1, 5'd1, 7'd0, 16'h0003, 1'b0, 10'd3);

    // Both requesting for 4 cycles; rr points at 0 here.
    bus.req_line[0] = 5'd0; bus.req_idx[0] = 7'd0;
    bus.req_line[1] = 5'd0; bus.req_idx[1] = 7'd2;
    bus.req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      int e;
`ifdef OPTION_STORE_FIXED_PRIORITY_EN
      e = 0;
`else
      e = k % 2;
`endif
      @(negedge clk);
      check("arb_grant", 32'(bus.grant), (e == 0) ? 1 : 2);
      check("arb_addr", 32'(bram_addr), (e == 0) ? 0 : 2);
      exp_q.push_back('{e[0], (e == 0) ? 16'h0007 : 16'h000D, 1'b0, cyc + 2});
      tick();
    end
    bus.req = 2'b00;
    repeat (4) tick();
    check("drain_1", exp_q.size(), 0);

    // Header while READY restarts the load at address 0.
    wr(1'b1, 16'd2);
    @(negedge clk);
    check("reload_clears_done", 32'(load_done), 0);
    tick();
    opt_exp(10'd0, 16'h0055);
    done();
    rd(0, 5'd2, 7'd0, 16'h0055, 1'b0, 10'd0);
    repeat (4) tick();

    // Reset with a granted read in flight: its rvalid must never appear.
    bus.req[0] = 1'b1; bus.req_line[0] = 5'd2; bus.req_idx[0] = 7'd0;
    @(negedge clk);
    check("inflight_grant", 32'(bus.grant), 1);
    tick();
    bus.req = 2'b00;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_outs", {29'(bus.grant), bus.rvalid, bus.oor, bram_we}, 0);
    check("post_rst_status", {load_done, overflow, bus.rdata, 6'(bram_addr)}, 0);
    repeat (4) tick();
    check("drain_2", exp_q.size(), 0);

    // Option before any header is dropped; a header then opens LOAD at address 0.
    wr(1'b0, 16'h0099);
    @(negedge clk);
    check("overflow_idle_opt", 32'(overflow), 1);
    tick();
    wr(1'b1, 16'd4);
    opt_exp(10'd0, 16'h0044);
    repeat (2) tick();
    check("writes_drained", wq.size(), 0);

    // DEPTH=4 instance: five options on line 0.
    bus2.wr_valid = 1'b1; bus2.wr_is_header = 1'b1; bus2.wr_data = 16'd0;
    tick();
    bus2.wr_is_header = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus2.wr_data = 16'h0011 + 16'(k);
      if (k == 4) begin
        @(negedge clk);
        check("d4_overflow_before", 32'(overflow2), 0);
        check("d4_fifth_not_written", 32'(bram_we2), 0);
      end
      tick();
    end
    bus2.wr_valid = 1'b0;
    bus2.board_done = 1'b1;
    tick();
    bus2.board_done = 1'b0;
    @(negedge clk);
    check("d4_writes", we2_cnt, 4);
    check("d4_overflow", 32'(overflow2), 1);
    check("d4_load_done", 32'(load_done2), 1);
    tick();
    for (int k = 3; k < 5; k++) begin
      bus2.req[0] = 1'b1; bus2.req_line[0] = 5'd0; bus2.req_idx[0] = 7'(k);
      @(negedge clk);
      check("d4_grant", 32'(bus2.grant), 1);
      check("d4_addr", 32'(bram_addr2), (k == 3) ? 3 : 0);
      tick();
      bus2.req[0] = 1'b0;
      tick();
      @(negedge clk);
      check("d4_rvalid", 32'(bus2.rvalid), 1);
      check("d4_rdata", 32'(bus2.rdata), (k == 3) ? 32'h14 : 0);
      check("d4_oor", 32'(bus2.oor), (k == 3) ? 0 : 1);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
